// File: rtl/edge_pe_sched_pkg.sv
// Shared definitions for the Edge PE replay-iteration scheduler.
//   Num_Edge_PE     : number of Edge PEs in the array
//   Max_replay_Iter : maximum number of replay iterations per run
//   sched_state_t   : scheduler FSM state encoding
package edge_pe_sched_pkg;

  localparam int unsigned Num_Edge_PE     = 4;
  localparam int unsigned Max_replay_Iter = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SYNC = 2'd2,
    ST_DONE = 2'd3
  } sched_state_t;

endpackage

// File: rtl/edge_pe_sched_busy.sv
// pe_busy_tracker: per-PE busy register with protocol-error detection.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   en         : tracking enabled (scheduler in RUN); inputs ignored otherwise
//   clr        : synchronous clear of all busy bits (run start)
//   dispatch   : bit i = task handed to PE i this cycle
//   pe_done    : bit i = PE i finished its task this cycle
//   busy       : registered per-PE busy state
//   err_pulse  : combinational, high in a cycle with a protocol violation
module pe_busy_tracker
  import edge_pe_sched_pkg::*;
#(
  parameter int unsigned NUM_PE = Num_Edge_PE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clr,
  input  logic [NUM_PE-1:0] dispatch,
  input  logic [NUM_PE-1:0] pe_done,
  output logic [NUM_PE-1:0] busy,
  output logic              err_pulse
);

  logic [NUM_PE-1:0] dbl_dispatch;
  logic [NUM_PE-1:0] orphan_done;

  // Dispatch to a PE still holding a task, or a completion from an idle PE.
  assign dbl_dispatch = dispatch & busy & ~pe_done;
  assign orphan_done  = pe_done & ~busy;
  assign err_pulse    = en & ((|dbl_dispatch) | (|orphan_done));

  // Dispatch wins over completion so a same-cycle done+dispatch keeps the PE busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else if (clr) begin
      busy <= '0;
    end else if (en) begin
      busy <= dispatch | (busy & ~pe_done);
    end
  end

endmodule

// File: rtl/edge_pe_sched.sv
// edge_pe_sched: replay-iteration scheduler for the Edge PE array.
// Tracks PE busy state, detects iteration end (dispatcher finished, RS empty,
// all PEs idle) and advances replay_Iter until the programmed count is reached.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   start       : begin a run (IDLE only); num_iter latched with it
//   dispatch    : per-PE task dispatch strobes from the RS
//   pe_done     : per-PE completion pulses
//   dp_last     : dispatcher pushed last packet of the iteration
//   rs_empty    : reservation station holds no valid entry
//   replay_Iter : current iteration index
//   PE_IDLE     : PE i may accept a task
//   iter_done   : pulse in the SYNC cycle closing each iteration
//   all_done    : pulse in the DONE cycle closing the run
//   sched_busy  : scheduler not in IDLE
//   iter_cycles : RUN cycles of the last completed iteration (saturating)
//   err         : sticky protocol-error flag
module edge_pe_sched
  import edge_pe_sched_pkg::*;
#(
  parameter int unsigned NUM_PE   = Num_Edge_PE,
  parameter int unsigned MAX_ITER = Max_replay_Iter,
  parameter int unsigned ITER_W   = $clog2(MAX_ITER),
  parameter int unsigned CYC_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ITER_W:0]   num_iter,
  input  logic [NUM_PE-1:0] dispatch,
  input  logic [NUM_PE-1:0] pe_done,
  input  logic              dp_last,
  input  logic              rs_empty,
  output logic [ITER_W-1:0] replay_Iter,
  output logic [NUM_PE-1:0] PE_IDLE,
  output logic              iter_done,
  output logic              all_done,
  output logic              sched_busy,
  output logic [CYC_W-1:0]  iter_cycles,
  output logic              err
);

  localparam int unsigned CNT_W = ITER_W + 1;

  sched_state_t      state;
  logic [NUM_PE-1:0] busy;
  logic              trk_err;
  logic              start_ok;
  logic              last_seen;
  logic              iter_end;
  logic [CNT_W-1:0]  num_iter_q;
  logic [CNT_W-1:0]  num_iter_clamped;
  logic [CNT_W-1:0]  last_iter;
  logic [CYC_W-1:0]  cyc_cnt;

  assign start_ok = (state == ST_IDLE) & start;

  pe_busy_tracker #(
    .NUM_PE (NUM_PE)
  ) u_busy (
    .clk       (clk),
    .reset     (reset),
    .en        (state == ST_RUN),
    .clr       (start_ok),
    .dispatch  (dispatch),
    .pe_done   (pe_done),
    .busy      (busy),
    .err_pulse (trk_err)
  );

  // Out-of-range counts are clamped so replay_Iter can never wrap.
  assign num_iter_clamped = (num_iter > CNT_W'(MAX_ITER)) ? CNT_W'(MAX_ITER) : num_iter;
  assign last_iter        = num_iter_q - CNT_W'(1);

  // Iteration end: dispatcher finished, RS drained, no PE busy, nothing in flight.
  assign iter_end = (last_seen | dp_last) & rs_empty & ~(|busy) & ~(|dispatch);

  // Scheduler FSM with iteration and cycle counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      replay_Iter <= '0;
      num_iter_q  <= '0;
      last_seen   <= 1'b0;
      cyc_cnt     <= '0;
      iter_cycles <= '0;
      err         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            num_iter_q  <= num_iter_clamped;
            replay_Iter <= '0;
            err         <= 1'b0;
            last_seen   <= 1'b0;
            cyc_cnt     <= '0;
            state       <= (num_iter == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (dp_last) last_seen <= 1'b1;
          if (trk_err) err <= 1'b1;
          if (cyc_cnt != '1) cyc_cnt <= cyc_cnt + CYC_W'(1);
          if (iter_end) state <= ST_SYNC;
        end
        ST_SYNC: begin
          iter_cycles <= cyc_cnt;
          cyc_cnt     <= '0;
          last_seen   <= 1'b0;
          if ({1'b0, replay_Iter} == last_iter) begin
            state <= ST_DONE;
          end else begin
            replay_Iter <= replay_Iter + ITER_W'(1);
            state       <= ST_RUN;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs are decodes of registered state only.
  assign PE_IDLE    = {NUM_PE{state == ST_RUN}} & ~busy;
  assign iter_done  = (state == ST_SYNC);
  assign all_done   = (state == ST_DONE);
  assign sched_busy = (state != ST_IDLE);

endmodule
